// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional 1-entry skid buffer,
// bubble insertion on flush/reset and saturating stall/flush event counters.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W = 32,
  parameter logic [DATA_W-1:0] BUBBLE = '0,
  parameter int unsigned       SKID   = 1,
  parameter int unsigned       CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] main_d, skid_d;
  logic              main_v, skid_v;
  logic              accept, issue;
  logic              load_main_in, load_main_skid, load_skid;

  assign main_v = (state != EMPTY);
  assign skid_v = (state == TWO);

  // Without the skid entry, ready must look through to out_ready to keep full throughput.
  assign in_ready  = (SKID != 0) ? (en & ~rst & ~skid_v)
                                 : (en & ~rst & (~main_v | out_ready));
  assign out_valid = en & main_v;
  assign out_data  = main_v ? main_d : BUBBLE;

  assign accept = en & in_valid & in_ready;
  assign issue  = en & out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else if (en) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt    = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && (issue || SKID == 0)) begin
            state_nxt    = ONE;
            load_main_in = 1'b1;
          end else if (accept) begin
            state_nxt = TWO;
            load_skid = 1'b1;
          end else if (issue) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (issue) begin
            state_nxt      = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_d    <= BUBBLE;
      skid_d    <= BUBBLE;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (en) begin
      if (load_main_in) begin
        main_d <= in_data;
      end else if (load_main_skid) begin
        main_d <= skid_d;
      end
      if (load_skid) begin
        skid_d <= in_data;
      end
      if (main_v && !out_ready && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush && (main_v || skid_v) && flush_cnt != '1) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid (main DUT), 4-bit counter and no-skid variants
// share the same stimulus; expected values are hand-computed per step.
module tb_pipe_stage_reg;

  logic        clk;
  logic        rst, en, flush, in_valid, out_ready;
  logic [31:0] in_data;

  logic        d_in_ready, d_out_valid;
  logic [31:0] d_out_data;
  logic [15:0] d_stall, d_flush;

  logic        t_in_ready, t_out_valid;
  logic [31:0] t_out_data;
  logic [3:0]  t_stall, t_flush;

  logic        z_in_ready, z_out_valid;
  logic [31:0] z_out_data;
  logic [15:0] z_stall, z_flush;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  pipe_stage_reg #(.DATA_W(32), .BUBBLE(32'h0000_0013), .SKID(1), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .in_valid(in_valid), .in_ready(d_in_ready), .in_data(in_data),
    .out_valid(d_out_valid), .out_ready(out_ready), .out_data(d_out_data),
    .stall_cnt(d_stall), .flush_cnt(d_flush)
  );

  pipe_stage_reg #(.DATA_W(32), .BUBBLE(32'h0000_0013), .SKID(1), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .in_valid(in_valid), .in_ready(t_in_ready), .in_data(in_data),
    .out_valid(t_out_valid), .out_ready(out_ready), .out_data(t_out_data),
    .stall_cnt(t_stall), .flush_cnt(t_flush)
  );

  pipe_stage_reg #(.DATA_W(32), .BUBBLE(32'h0000_0013), .SKID(0), .CNT_W(16)) u_s0 (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .in_valid(in_valid), .in_ready(z_in_ready), .in_data(in_data),
    .out_valid(z_out_valid), .out_ready(out_ready), .out_data(z_out_data),
    .stall_cnt(z_stall), .flush_cnt(z_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // reset
    tick(); tick();
    chk("rst_in_ready",   32'(d_in_ready), 32'd0);
    chk("rst_out_valid",  32'(d_out_valid), 32'd0);
    chk("rst_out_data",   d_out_data, 32'h13);
    chk("rst_stall",      32'(d_stall), 32'd0);
    chk("rst_flush",      32'(d_flush), 32'd0);
    chk("rst_sat_stall",  32'(t_stall), 32'd0);
    chk("rst_s0_valid",   32'(z_out_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready",    32'(d_in_ready), 32'd1);
    chk("post_rst_s0_in_ready", 32'(z_in_ready), 32'd1);

    // streaming at full rate
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(32'hA0 + i);
      #1;
      chk("stream_in_ready", 32'(d_in_ready), 32'd1);
      tick();
      chk("stream_valid",   32'(d_out_valid), 32'd1);
      chk("stream_data",    d_out_data, 32'(32'hA0 + i));
      chk("stream_s0_data", z_out_data, 32'(32'hA0 + i));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drain_valid", 32'(d_out_valid), 32'd0);
    chk("stream_drain_data",  d_out_data, 32'h13);
    chk("stream_stall",       32'(d_stall), 32'd0);

    // backpressure into the skid entry
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hB1;
    tick();
    chk("skid_b1",    d_out_data, 32'hB1);
    chk("skid_s0_b1", z_out_data, 32'hB1);
    in_data = 32'hB2;
    #1;
    chk("skid_one_ready",   32'(d_in_ready), 32'd1);
    chk("skid_s0_no_ready", 32'(z_in_ready), 32'd0);
    tick();
    chk("skid_hold_b1", d_out_data, 32'hB1);
    in_data = 32'hB3;
    #1;
    chk("skid_two_ready", 32'(d_in_ready), 32'd0);
    tick(); tick();
    chk("skid_hold_b1_2", d_out_data, 32'hB1);
    chk("skid_stall",     32'(d_stall), 32'd3);
    chk("skid_s0_stall",  32'(z_stall), 32'd3);
    out_ready = 1'b1;
    #1;
    chk("skid_ready_registered", 32'(d_in_ready), 32'd0);
    tick();
    chk("skid_out_b2",   d_out_data, 32'hB2);
    chk("skid_ready_one", 32'(d_in_ready), 32'd1);
    tick();
    chk("skid_out_b3", d_out_data, 32'hB3);
    in_valid = 1'b0;
    tick();
    chk("skid_drained",       32'(d_out_valid), 32'd0);
    chk("skid_stall_final",   32'(d_stall), 32'd3);
    chk("skid_s0_drained",    32'(z_out_valid), 32'd0);

    // flush while holding two entries
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hC1;
    tick();
    in_data = 32'hC2;
    tick();
    flush = 1'b1; in_data = 32'hC3;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid",    32'(d_out_valid), 32'd0);
    chk("flush_data",     d_out_data, 32'h13);
    chk("flush_cnt",      32'(d_flush), 32'd1);
    chk("flush_stall",    32'(d_stall), 32'd5);
    chk("flush_s0_cnt",   32'(z_flush), 32'd1);
    // accepted in a flush cycle while empty: dropped, not counted
    flush = 1'b1; in_valid = 1'b1; in_data = 32'hD1;
    #1;
    chk("flush_empty_ready", 32'(d_in_ready), 32'd1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_drop_valid", 32'(d_out_valid), 32'd0);
    chk("flush_empty_cnt",  32'(d_flush), 32'd1);

    // global enable low mid-stream
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hE1;
    tick();
    chk("en_e1", d_out_data, 32'hE1);
    en = 1'b0; in_data = 32'hE2; out_ready = 1'b0;
    #1;
    chk("en_off_ready", 32'(d_in_ready), 32'd0);
    chk("en_off_valid", 32'(d_out_valid), 32'd0);
    repeat (5) tick();
    chk("en_off_valid_2", 32'(d_out_valid), 32'd0);
    chk("en_off_data",    d_out_data, 32'hE1);
    chk("en_off_stall",   32'(d_stall), 32'd5);
    chk("en_off_flush",   32'(d_flush), 32'd1);
    chk("en_off_s0_data", z_out_data, 32'hE1);
    en = 1'b1; out_ready = 1'b1;
    #1;
    chk("en_on_valid", 32'(d_out_valid), 32'd1);
    chk("en_on_data",  d_out_data, 32'hE1);
    chk("en_on_ready", 32'(d_in_ready), 32'd1);
    tick();
    chk("en_on_e2", d_out_data, 32'hE2);
    in_valid = 1'b0;
    tick();
    chk("en_on_drained", 32'(d_out_valid), 32'd0);

    // counter saturation and reset clear
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hF1;
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    chk("sat_stall4",  32'(t_stall), 32'd15);
    chk("sat_stall16", 32'(d_stall), 32'd25);
    chk("sat_s0",      32'(z_stall), 32'd25);
    chk("sat_data",    d_out_data, 32'hF1);
    rst = 1'b1;
    tick();
    chk("rst2_stall4", 32'(t_stall), 32'd0);
    chk("rst2_stall",  32'(d_stall), 32'd0);
    chk("rst2_flush",  32'(d_flush), 32'd0);
    chk("rst2_valid",  32'(d_out_valid), 32'd0);
    chk("rst2_data",   d_out_data, 32'h13);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
